// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu (+ alu_share_arbiter)
//  Description : 32-bit combinational ALU, shared by two requesters through a
//                valid/ready arbiter and an IDLE/EXEC/RESP sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================

// Combinational ALU; undefined function codes yield zero.
module alu (
    input  logic [4:0]  i_func,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    output logic [31:0] o_result
);
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    // Shifts use the whole of op_b, so amounts of 32 or more flush the operand.
    always_comb begin
        o_result = 32'd0;
        case (i_func)
            ALU_ADD:  o_result = i_op_a + i_op_b;
            ALU_SUB:  o_result = i_op_a - i_op_b;
            ALU_SLL:  o_result = i_op_a << i_op_b;
            ALU_SLT:  o_result = {31'd0, $signed(i_op_a) < $signed(i_op_b)};
            ALU_SLTU: o_result = {31'd0, i_op_a < i_op_b};
            ALU_XOR:  o_result = i_op_a ^ i_op_b;
            ALU_SRL:  o_result = i_op_a >> i_op_b;
            ALU_SRA:  o_result = $unsigned($signed(i_op_a) >>> i_op_b);
            ALU_OR:   o_result = i_op_a | i_op_b;
            ALU_AND:  o_result = i_op_a & i_op_b;
            default:  o_result = 32'd0;
        endcase
    end
endmodule

module alu_share_arbiter #(
    parameter bit RR_ENABLE = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [4:0]       req_func0,
    input  logic [4:0]       req_func1,
    input  logic [31:0]      req_a0,
    input  logic [31:0]      req_a1,
    input  logic [31:0]      req_b0,
    input  logic [31:0]      req_b1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_eq_zero,
    output logic             busy,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic [4:0]      r_func;
    logic [31:0]     r_op_a;
    logic [31:0]     r_op_b;
    logic            r_owner;
    logic            r_rr_ptr;
    logic [31:0]     r_rsp_result;
    logic            r_rsp_eq_zero;
    logic [1:0]      r_rsp_valid;
    logic [CNT_W-1:0] r_grant_cnt0;
    logic [CNT_W-1:0] r_grant_cnt1;

    logic            w_grant;
    logic [1:0]      w_req_ready;
    logic            w_req_fire;
    logic            w_rsp_fire;
    logic [31:0]     w_alu_result;

    // Pick the winner among valid requesters; ready is only offered in IDLE.
    always_comb begin
        w_grant     = 1'b0;
        w_req_ready = 2'b00;
        case (req_valid)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = RR_ENABLE ? r_rr_ptr : 1'b0;
            default: w_grant = 1'b0;
        endcase
        if (r_state == S_IDLE && req_valid != 2'b00) begin
            w_req_ready = w_grant ? 2'b10 : 2'b01;
        end
    end

    assign w_req_fire = |(req_valid & w_req_ready);
    assign w_rsp_fire = (r_state == S_RESP) && rsp_ready[r_owner];

    alu u_alu (
        .i_func   (r_func),
        .i_op_a   (r_op_a),
        .i_op_b   (r_op_b),
        .o_result (w_alu_result)
    );

    // Sequencer: latch on request handshake, compute, then hold the response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_func        <= 5'd0;
            r_op_a        <= 32'd0;
            r_op_b        <= 32'd0;
            r_owner       <= 1'b0;
            r_rr_ptr      <= 1'b0;
            r_rsp_result  <= 32'd0;
            r_rsp_eq_zero <= 1'b1;
            r_rsp_valid   <= 2'b00;
            r_grant_cnt0  <= '0;
            r_grant_cnt1  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_fire) begin
                        r_func   <= w_grant ? req_func1 : req_func0;
                        r_op_a   <= w_grant ? req_a1    : req_a0;
                        r_op_b   <= w_grant ? req_b1    : req_b0;
                        r_owner  <= w_grant;
                        r_rr_ptr <= ~w_grant;
                        if (w_grant) r_grant_cnt1 <= r_grant_cnt1 + CNT_W'(1);
                        else         r_grant_cnt0 <= r_grant_cnt0 + CNT_W'(1);
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_result  <= w_alu_result;
                    r_rsp_eq_zero <= (w_alu_result == 32'd0);
                    r_rsp_valid   <= r_owner ? 2'b10 : 2'b01;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_fire) begin
                        r_rsp_valid <= 2'b00;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 2'b00;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = w_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_eq_zero = r_rsp_eq_zero;
    assign busy        = (r_state != S_IDLE);
    assign grant_cnt0  = r_grant_cnt0;
    assign grant_cnt1  = r_grant_cnt1;
endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational `alu` instance between two requesters, e.g. an integer pipeline port (0) and a debug/auxiliary port (1).
- Each port has a valid/ready request channel and a valid/ready response channel.
- Requests go through a 3-state sequencer (IDLE, EXEC, RESP) and one operation is in flight at a time.
- Round-robin or fixed-priority arbitration selects between simultaneous requests; per-port grant counters support performance checks.

Parameters:
- RR_ENABLE, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.
- CNT_W, 16, width of each per-port grant counter.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  2  per-port request valid; bit i belongs to port i.
- req_ready  output  2  per-port request accept; a handshake occurs when valid and ready are both high.
- req_func0, req_func1  input  5 each  ALU function code, using the `ALU_*` encodings from constants.svh.
- req_a0, req_a1  input  32 each  operand A per port.
- req_b0, req_b1  input  32 each  operand B per port.
- rsp_valid  output  2  per-port response valid.
- rsp_ready  input  2  per-port response accept.
- rsp_result  output  32  registered ALU result; meaningful only for the port whose rsp_valid is set.
- rsp_eq_zero  output  1  high when rsp_result == 0.
- busy  output  1  high in EXEC or RESP.
- grant_cnt0, grant_cnt1  output  CNT_W each  number of accepted requests per port.

Behaviour:
- Reset (asynchronous):
  - state = IDLE; rsp_valid = 0; rsp_result = 0; rsp_eq_zero = 1; busy = 0.
  - Both grant counters = 0; round-robin pointer = port 0.
  - The latched func/operands/owner registers are cleared.
  - Reset mid-operation discards any in-flight op or pending response without emitting it.
- req_ready:
  - Combinational. Only the granted port may see ready, and only in IDLE.
  - Elsewhere req_ready = 2'b00.
- Arbitration in IDLE:
  - One requester valid: that requester is granted.
  - Both valid, RR_ENABLE=1: the port named by the pointer is granted. After each accepted request the pointer moves to the other port.
  - Both valid, RR_ENABLE=0: port 0 is granted and the pointer is unused.
  - Requesters may drop valid before a handshake; no request is latched without a handshake.
- IDLE to EXEC, on handshake in cycle T:
  - Latch func, op_a, op_b and the owner id.
  - Increment that port's grant counter; it wraps modulo 2^CNT_W.
- EXEC (cycle T+1):
  - The shared `alu` sees the latched func/operands.
  - rsp_result <= ALU result; rsp_eq_zero <= (ALU result == 0); state moves to RESP.
- RESP (from cycle T+2):
  - rsp_valid[owner] = 1; the other bit is 0.
  - rsp_result and rsp_eq_zero stay stable until rsp_ready[owner] is high.
  - The cycle after that response handshake, state returns to IDLE.
  - rsp_ready on the non-owner port is ignored.
- Latency and throughput:
  - Minimum request-to-response latency is 2 cycles.
  - Minimum spacing between accepted requests is 3 cycles; a new request cannot be accepted in the same cycle as a response handshake.
- Function codes: an undefined code yields result 0 and rsp_eq_zero = 1, with a normal handshake.
- Arithmetic:
  - Exactly the `alu` semantics: 32-bit wrap-around add/sub.
  - Shift amount is the full op_b.
  - SLT is signed compare; SLTU is unsigned compare.
- busy = (state != IDLE).

Test Plan:
- Reset then single op:
  - Stimulus: port 0, `ALU_ADD`, a=0x7FFFFFFF, b=1.
  - Response: rsp_valid[0] at T+2, result 0x80000000, eq_zero=0, grant_cnt0=1.
- Simultaneous requests, RR_ENABLE=1, rsp_ready held high:
  - Stimulus: both ports hold valid — port 0 `ALU_SUB` 5-5, port 1 `ALU_XOR` 0xF0F0-0x0F0F.
  - Response: port 0 served first with result 0 and eq_zero=1; port 1 next with 0xFFFF; a further port 0 request wins next.
- Fixed priority, RR_ENABLE=0:
  - Stimulus: both ports valid continuously for 4 ops.
  - Response: all 4 grants go to port 0; grant_cnt1 stays 0.
- Response backpressure:
  - Stimulus: rsp_ready[1] held low for 5 cycles on port 1 `ALU_SLT` a=0xFFFFFFFF, b=1.
  - Response: rsp_result stays 1, req_ready stays 00 and busy stays 1 throughout; IDLE follows the cycle after rsp_ready rises.
- Reset mid-operation:
  - Stimulus: assert reset while in RESP with rsp_valid[0]=1.
  - Response: rsp_valid drops immediately and asynchronously; counters are 0; the next grant after release goes to port 0 even if both ports request.
- Undefined function and counter wrap:
  - Stimulus: function code 5'b11111.
  - Response: result 0, eq_zero=1.
  - Stimulus: with CNT_W=2, issue 5 requests on port 1.
  - Response: grant_cnt1=1.
